// File: rtl/regfile_write_queue.sv
// Write-side queue for the 32x32 register file: orders ALU/load writebacks, retires one
// write per cycle, and forwards the youngest pending value to the read ports.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        RN1,
  input  logic [ADDR_W-1:0]        RN2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [ADDR_W-1:0]        WN,
  output logic [DATA_W-1:0]        WD,
  output logic                     RegWrite,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_wr;
  logic [ADDR_W-1:0] r_wn;
  logic [DATA_W-1:0] r_wd;
  logic              r_ovf;

  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_mem_drop;
  logic              w_alu_drop;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_ptr;
  logic [CNT_W-1:0]  w_push_n;

  // Ready depends only on the current count, so two slots are always free when asserted.
  assign in_ready   = (r_count <= CNT_W'(DEPTH - 2));
  assign w_mem_acc  = mem_valid && (mem_rd != '0) && in_ready;
  assign w_alu_acc  = alu_valid && (alu_rd != '0) && in_ready;
  assign w_mem_drop = mem_valid && (mem_rd != '0) && !in_ready;
  assign w_alu_drop = alu_valid && (alu_rd != '0) && !in_ready;
  assign w_pop      = (r_count != '0);
  assign w_alu_ptr  = w_mem_acc ? (r_wptr + PTR_W'(1)) : r_wptr;
  assign w_push_n   = CNT_W'(w_mem_acc) + CNT_W'(w_alu_acc);

  always_ff @(posedge clock) begin
    if (w_mem_acc) begin
      r_rd[r_wptr]   <= mem_rd;
      r_data[r_wptr] <= mem_data;
    end
    if (w_alu_acc) begin
      r_rd[w_alu_ptr]   <= alu_rd;
      r_data[w_alu_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wr    <= 1'b0;
      r_wn    <= '0;
      r_wd    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_push_n);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + w_push_n - CNT_W'(w_pop);
      if (w_pop) begin
        r_wn <= r_rd[r_rptr];
        r_wd <= r_data[r_rptr];
        r_wr <= 1'b1;
      end else begin
        r_wr <= 1'b0;
      end
      if (w_mem_drop || w_alu_drop) r_ovf <= 1'b1;
    end
  end

  // Output stage is the oldest candidate; scanning queue oldest-to-youngest lets the youngest win.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (r_wr && (RN1 != '0) && (r_wn == RN1)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = r_wd;
    end
    if (r_wr && (RN2 != '0) && (r_wn == RN2)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = r_wd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) begin
        if ((RN1 != '0) && (r_rd[r_rptr + PTR_W'(i)] == RN1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[r_rptr + PTR_W'(i)];
        end
        if ((RN2 != '0) && (r_rd[r_rptr + PTR_W'(i)] == RN2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[r_rptr + PTR_W'(i)];
        end
      end
    end
  end

  assign WN       = r_wn;
  assign WD       = r_wd;
  assign RegWrite = r_wr;
  assign count    = r_count;
  assign empty    = (r_count == '0) && !r_wr;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        in_ready;
  logic [4:0]  RN1;
  logic [4:0]  RN2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic        RegWrite;
  logic [2:0]  count;
  logic        empty;
  logic        overflow;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready), .RN1(RN1), .RN2(RN2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .WN(WN), .WD(WD), .RegWrite(RegWrite),
    .count(count), .empty(empty), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic        m_wr;
  logic [4:0]  m_wn;
  logic [31:0] m_wd;
  logic        m_ovf;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_wr  = 1'b0;
    m_wn  = '0;
    m_wd  = '0;
    m_ovf = 1'b0;
  endfunction

  // Youngest queued match first, then the entry being written this cycle.
  function automatic void model_fwd(input logic [4:0] rn, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rn != 0) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (!hit && m_q[i].rd == rn) begin
          hit = 1'b1;
          d   = m_q[i].data;
        end
      end
      if (!hit && m_wr && m_wn == rn) begin
        hit = 1'b1;
        d   = m_wd;
      end
    end
  endfunction

  function automatic void model_edge();
    ent_t e;
    logic rdy;
    rdy = (DEPTH - m_q.size()) >= 2;
    if (m_q.size() > 0) begin
      e    = m_q.pop_front();
      m_wr = 1'b1;
      m_wn = e.rd;
      m_wd = e.data;
    end else begin
      m_wr = 1'b0;
    end
    if (mem_valid && mem_rd != 0) begin
      if (rdy) m_q.push_back('{mem_rd, mem_data});
      else     m_ovf = 1'b1;
    end
    if (alu_valid && alu_rd != 0) begin
      if (rdy) m_q.push_back('{alu_rd, alu_data});
      else     m_ovf = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    logic        h;
    logic [31:0] d;
    chk("count", count, m_q.size());
    chk("in_ready", in_ready, (DEPTH - m_q.size()) >= 2);
    chk("empty", empty, (m_q.size() == 0) && !m_wr);
    chk("RegWrite", RegWrite, m_wr);
    chk("WN", WN, m_wn);
    chk("WD", WD, m_wd);
    chk("overflow", overflow, m_ovf);
    model_fwd(RN1, h, d);
    chk("fwd1_hit", fwd1_hit, h);
    chk("fwd1_data", fwd1_data, d);
    model_fwd(RN2, h, d);
    chk("fwd2_hit", fwd2_hit, h);
    chk("fwd2_data", fwd2_data, d);
  endtask

  task automatic cycle(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] rn1, input logic [4:0] rn2);
    @(posedge clock);
    #1;
    model_edge();
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    RN1       = rn1;
    RN2       = rn2;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [4:0] rn1, input logic [4:0] rn2);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, rn1, rn2);
  endtask

  task automatic zero_inputs();
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    RN1 = 0; RN2 = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    zero_inputs();
    model_clear();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_outputs();

    // single write with forwarding on RN1
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    idle(4, 5, 0);

    // dual issue to the same register: mem older than alu
    cycle(1, 3, 32'h11, 1, 3, 32'h22, 0, 3);
    idle(4, 3, 3);

    // register zero is discarded and never forwarded
    cycle(0, 0, 0, 1, 0, 32'h1234, 0, 0);
    idle(3, 0, 0);

    // overflow: both sources every cycle for 4 cycles
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(2 * i + 1), 32'hA000 + 32'(i), 1, 5'(2 * i + 2), 32'hB000 + 32'(i), 5'(i + 1), 5'(i + 2));
    idle(6, 3, 4);

    // async reset with three entries queued
    cycle(1, 7, 32'h70, 1, 8, 32'h80, 7, 8);
    cycle(1, 9, 32'h90, 1, 10, 32'hA0, 9, 10);
    cycle(0, 0, 0, 0, 0, 0, 9, 10);
    @(posedge clock);
    #3;
    zero_inputs();
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_count", count, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_fwd1", fwd1_hit, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(4, 9, 10);

    // random traffic at several loads, including wraps and overflow
    for (int ph = 0; ph < 3; ph++) begin
      int rate;
      rate = (ph == 0) ? 30 : (ph == 1) ? 55 : 85;
      for (int c = 0; c < 120; c++) begin
        cycle($urandom_range(0, 99) < rate, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < rate, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(6, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
